player_core: RTL and testbench

Player-side executor for the dodge phase. Consumes the 16-bit player instruction word, `isMove` and `startDmg` strobes that the game state machine drives. Maintains player HP and on-screen position inside the dodge box. Returns `isDeath` and a one-cycle damage acknowledge to the state machine, and exposes HP and position to the renderer.

---
 rtl/game_pkg.sv | 28 ++
 rtl/instr_decode.sv | 32 +++
 rtl/player_core.sv | 157 +++++++++++++++
 tb/tb_player_core.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared game definitions: instruction field layout, opcodes, move directions
// and the player state encoding. The state machine and renderer import this too.
package game_pkg;

    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int OPD_MSB = 11;
    localparam int OPD_LSB = 4;

    localparam logic [3:0] HPY = 4'd1;
    localparam logic [3:0] DPY = 4'd2;
    localparam logic [3:0] IDG = 4'd3;
    localparam logic [3:0] SDG = 4'd4;
    localparam logic [3:0] MOV = 4'd5;
    localparam logic [3:0] SHP = 4'd6;

    localparam logic [1:0] UP    = 2'd0;
    localparam logic [1:0] LEFT  = 2'd1;
    localparam logic [1:0] DOWN  = 2'd2;
    localparam logic [1:0] RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_ALIVE = 2'd0,
        ST_HIT   = 2'd1,
        ST_DEAD  = 2'd2
    } player_state_e;

endpackage

// File: rtl/instr_decode.sv
// Combinational split of the 16-bit player instruction word into the
// heal / damage / move qualifiers, the 8-bit amount and the move direction.
module instr_decode
    import game_pkg::*;
(
    input  logic [15:0] instr_i,
    output logic        is_heal_o,
    output logic        is_dmg_o,
    output logic        is_mov_o,
    output logic [7:0]  amount_o,
    output logic [1:0]  dir_o,
    output logic        dir_valid_o
);

    logic [3:0] opcode;
    logic [7:0] operand;
    logic       unused_low_bits;

    assign opcode  = instr_i[OPC_MSB:OPC_LSB];
    assign operand = instr_i[OPD_MSB:OPD_LSB];

    assign is_heal_o   = (opcode == HPY);
    assign is_dmg_o    = (opcode == DPY);
    assign is_mov_o    = (opcode == MOV);
    assign amount_o    = operand;
    assign dir_o       = operand[1:0];
    // Operands above RIGHT are not directions; such a MOV is a no-op.
    assign dir_valid_o = (operand[7:2] == 6'd0);

    assign unused_low_bits = ^instr_i[OPD_LSB-1:0];

endmodule

// File: rtl/player_core.sv
// Player executor for the dodge phase: HP, position, hit invulnerability,
// move pacing and the damage acknowledge back to the game state machine.
module player_core
    import game_pkg::*;
#(
    parameter int HP_MAX   = 100,
    parameter int STEP     = 4,
    parameter int MOVE_GAP = 3,
    parameter int INVULN   = 8,
    parameter int X_MIN    = 200,
    parameter int X_MAX    = 440,
    parameter int Y_MIN    = 240,
    parameter int Y_MAX    = 400,
    parameter int X_START  = 320,
    parameter int Y_START  = 320
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] playerInstruction,
    input  logic        isMove,
    input  logic        startDmg,
    input  logic        respawn,
    output logic [7:0]  hp,
    output logic [9:0]  posX,
    output logic [9:0]  posY,
    output logic        isDeath,
    output logic        dmgAck
);

    localparam int GAP_W = $clog2(MOVE_GAP + 1);
    localparam int INV_W = $clog2(INVULN + 1);

    localparam logic signed [10:0] STEP_S  = 11'(STEP);
    localparam logic signed [10:0] X_MIN_S = 11'(X_MIN);
    localparam logic signed [10:0] X_MAX_S = 11'(X_MAX);
    localparam logic signed [10:0] Y_MIN_S = 11'(Y_MIN);
    localparam logic signed [10:0] Y_MAX_S = 11'(Y_MAX);

    logic       is_heal, is_dmg, is_mov, dir_valid;
    logic [7:0] amount;
    logic [1:0] dir;

    player_state_e    state_q, state_d;
    logic [7:0]       hp_q, hp_d;
    logic [9:0]       pos_x_q, pos_x_d;
    logic [9:0]       pos_y_q, pos_y_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [INV_W-1:0] inv_q, inv_d;
    logic             ack_q, ack_d;
    logic             dead_q, dead_d;

    logic [8:0]         heal_sum;
    logic [7:0]         heal_val, dmg_val;
    logic signed [10:0] next_x, next_y;

    instr_decode u_decode (
        .instr_i     (playerInstruction),
        .is_heal_o   (is_heal),
        .is_dmg_o    (is_dmg),
        .is_mov_o    (is_mov),
        .amount_o    (amount),
        .dir_o       (dir),
        .dir_valid_o (dir_valid)
    );

    // HP arithmetic: 9-bit heal sum cannot wrap before the ceiling clamp.
    assign heal_sum = {1'b0, hp_q} + {1'b0, amount};
    assign heal_val = (heal_sum > 9'(HP_MAX)) ? 8'(HP_MAX) : heal_sum[7:0];
    assign dmg_val  = (amount >= hp_q) ? 8'd0 : hp_q - amount;

    // Signed 11-bit so a step below zero clamps to the box edge instead of wrapping.
    always_comb begin
        next_x = $signed({1'b0, pos_x_q});
        next_y = $signed({1'b0, pos_y_q});
        case (dir)
            UP:      next_y = next_y - STEP_S;
            LEFT:    next_x = next_x - STEP_S;
            DOWN:    next_y = next_y + STEP_S;
            RIGHT:   next_x = next_x + STEP_S;
            default: ;
        endcase
        if (next_x < X_MIN_S)      next_x = X_MIN_S;
        else if (next_x > X_MAX_S) next_x = X_MAX_S;
        if (next_y < Y_MIN_S)      next_y = Y_MIN_S;
        else if (next_y > Y_MAX_S) next_y = Y_MAX_S;
    end

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path infers a latch.
        state_d = state_q;
        hp_d    = hp_q;
        pos_x_d = pos_x_q;
        pos_y_d = pos_y_q;
        gap_d   = (gap_q != '0) ? gap_q - 1'b1 : gap_q;
        inv_d   = inv_q;
        ack_d   = 1'b0;

        if (state_q == ST_HIT) begin
            inv_d = (inv_q != '0) ? inv_q - 1'b1 : inv_q;
            if (inv_q <= INV_W'(1)) state_d = ST_ALIVE;
        end

        if (respawn) begin
            state_d = ST_ALIVE;
            hp_d    = 8'(HP_MAX);
            pos_x_d = 10'(X_START);
            pos_y_d = 10'(Y_START);
            gap_d   = '0;
            inv_d   = '0;
        end else if (startDmg) begin
            ack_d = 1'b1;
            if (state_q != ST_DEAD && is_heal) begin
                hp_d = heal_val;
            end else if (state_q == ST_ALIVE && is_dmg) begin
                hp_d    = dmg_val;
                state_d = (dmg_val == 8'd0) ? ST_DEAD : ST_HIT;
                inv_d   = (dmg_val == 8'd0) ? '0 : INV_W'(INVULN);
            end
        end else if (isMove && is_mov && dir_valid && gap_q == '0 && state_q != ST_DEAD) begin
            pos_x_d = next_x[9:0];
            pos_y_d = next_y[9:0];
            gap_d   = GAP_W'(MOVE_GAP);
        end

        dead_d = (state_d == ST_DEAD);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_ALIVE;
            hp_q    <= 8'(HP_MAX);
            pos_x_q <= 10'(X_START);
            pos_y_q <= 10'(Y_START);
            gap_q   <= '0;
            inv_q   <= '0;
            ack_q   <= 1'b0;
            dead_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hp_q    <= hp_d;
            pos_x_q <= pos_x_d;
            pos_y_q <= pos_y_d;
            gap_q   <= gap_d;
            inv_q   <= inv_d;
            ack_q   <= ack_d;
            dead_q  <= dead_d;
        end
    end

    assign hp      = hp_q;
    assign posX    = pos_x_q;
    assign posY    = pos_y_q;
    assign isDeath = dead_q;
    assign dmgAck  = ack_q;

endmodule

// File: tb/tb_player_core.sv
// Self-checking bench for player_core: directed scenarios then random traffic,
// every cycle compared against a timestamp-based behavioural model.
module tb_player_core;

    localparam int HP_MAX   = 100;
    localparam int STEP     = 4;
    localparam int MOVE_GAP = 3;
    localparam int INVULN   = 8;
    localparam int X_MIN    = 200;
    localparam int X_MAX    = 440;
    localparam int Y_MIN    = 240;
    localparam int Y_MAX    = 400;
    localparam int X_START  = 320;
    localparam int Y_START  = 320;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] playerInstruction = 16'd0;
    logic        isMove = 1'b0;
    logic        startDmg = 1'b0;
    logic        respawn = 1'b0;
    logic [7:0]  hp;
    logic [9:0]  posX;
    logic [9:0]  posY;
    logic        isDeath;
    logic        dmgAck;

    player_core #(
        .HP_MAX(HP_MAX), .STEP(STEP), .MOVE_GAP(MOVE_GAP), .INVULN(INVULN),
        .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MIN(Y_MIN), .Y_MAX(Y_MAX),
        .X_START(X_START), .Y_START(Y_START)
    ) dut (
        .clk(clk), .reset(reset), .playerInstruction(playerInstruction),
        .isMove(isMove), .startDmg(startDmg), .respawn(respawn),
        .hp(hp), .posX(posX), .posY(posY), .isDeath(isDeath), .dmgAck(dmgAck)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: HP/position as integers; pacing expressed as "edge of last accepted event".
    int m_hp, m_x, m_y, m_edge, m_last_mov, m_last_dpy;
    bit m_dead, m_ack;

    function automatic int clampi(input int v, input int lo, input int hi);
        return (v < lo) ? lo : (v > hi) ? hi : v;
    endfunction

    task automatic model_step();
        int op, opd;
        op  = int'(playerInstruction[15:12]);
        opd = int'(playerInstruction[11:4]);
        m_edge++;
        if (reset || respawn) begin
            m_hp = HP_MAX; m_x = X_START; m_y = Y_START;
            m_dead = 1'b0; m_ack = 1'b0;
            m_last_mov = -1000; m_last_dpy = -1000;
        end else begin
            m_ack = startDmg;
            if (startDmg) begin
                if (!m_dead && op == 1) begin
                    m_hp = (m_hp + opd > HP_MAX) ? HP_MAX : m_hp + opd;
                end else if (!m_dead && op == 2 && m_edge >= m_last_dpy + INVULN + 1) begin
                    m_hp = (opd >= m_hp) ? 0 : m_hp - opd;
                    m_last_dpy = m_edge;
                    m_dead = (m_hp == 0);
                end
            end else if (isMove && !m_dead && op == 5 && opd <= 3 &&
                         m_edge >= m_last_mov + MOVE_GAP + 1) begin
                case (opd)
                    0: m_y = clampi(m_y - STEP, Y_MIN, Y_MAX);
                    1: m_x = clampi(m_x - STEP, X_MIN, X_MAX);
                    2: m_y = clampi(m_y + STEP, Y_MIN, Y_MAX);
                    default: m_x = clampi(m_x + STEP, X_MIN, X_MAX);
                endcase
                m_last_mov = m_edge;
            end
        end
    endtask

    function automatic logic [15:0] ins(input int op, input int opd);
        logic [3:0] low;
        low = 4'($urandom);
        return {op[3:0], opd[7:0], low};
    endfunction

    task automatic cycle(input logic [15:0] w, input logic mv, input logic sd,
                         input logic rs, input logic rst);
        playerInstruction = w;
        isMove   = mv;
        startDmg = sd;
        respawn  = rs;
        reset    = rst;
        @(posedge clk);
        model_step();
        #1;
        check("model_hp", hp, m_hp);
        check("model_posX", posX, m_x);
        check("model_posY", posY, m_y);
        check("model_isDeath", isDeath, m_dead);
        check("model_dmgAck", dmgAck, m_ack);
    endtask

    task automatic idle();
        cycle(ins(0, 0), 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset values
        cycle(ins(0, 0), 1'b0, 1'b0, 1'b0, 1'b1);
        check("rst_hp", hp, 100);
        check("rst_posX", posX, 320);
        check("rst_posY", posY, 320);
        check("rst_isDeath", isDeath, 0);
        check("rst_dmgAck", dmgAck, 0);

        // Damage, then a second hit inside invulnerability still acknowledged
        cycle(ins(2, 30), 1'b0, 1'b1, 1'b0, 1'b0);
        check("dpy30_hp", hp, 70);
        check("dpy30_ack", dmgAck, 1);
        idle();
        check("ack_one_cycle", dmgAck, 0);
        cycle(ins(2, 30), 1'b0, 1'b1, 1'b0, 1'b0);
        check("dpy_in_hit_hp", hp, 70);
        check("dpy_in_hit_ack", dmgAck, 1);

        // Heal, including clamp at HP_MAX
        cycle(ins(1, 10), 1'b0, 1'b1, 1'b0, 1'b0);
        check("hpy10_hp", hp, 80);
        repeat (10) idle();
        cycle(ins(1, 15), 1'b0, 1'b1, 1'b0, 1'b0);
        check("hpy15_hp", hp, 95);
        cycle(ins(1, 10), 1'b0, 1'b1, 1'b0, 1'b0);
        check("hpy_clamp_hp", hp, 100);

        // Death, ignored move while dead, respawn
        cycle(ins(2, 80), 1'b0, 1'b1, 1'b0, 1'b0);
        check("dpy80_hp", hp, 20);
        repeat (10) idle();
        cycle(ins(2, 50), 1'b0, 1'b1, 1'b0, 1'b0);
        check("death_hp", hp, 0);
        check("death_flag", isDeath, 1);
        cycle(ins(5, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        check("dead_move_posX", posX, 320);
        cycle(ins(0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        check("respawn_hp", hp, 100);
        check("respawn_posX", posX, 320);
        check("respawn_isDeath", isDeath, 0);

        // Move pacing and clamping at the box edges
        repeat (16) cycle(ins(5, 3), 1'b1, 1'b0, 1'b0, 1'b0);
        check("hold_right_posX", posX, 336);
        repeat (160) cycle(ins(5, 1), 1'b1, 1'b0, 1'b0, 1'b0);
        check("walk_left_clamp", posX, 200);

        // Damage wins over a simultaneous move; the move gap is not loaded
        cycle(ins(0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(ins(2, 5), 1'b1, 1'b1, 1'b0, 1'b0);
        check("dmg_vs_move_hp", hp, 95);
        check("dmg_vs_move_posY", posY, 320);
        cycle(ins(5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        check("move_after_dmg_posY", posY, 316);
        repeat (100) cycle(ins(5, 0), 1'b1, 1'b0, 1'b0, 1'b0);
        check("walk_up_clamp", posY, 240);

        // No-op opcode under startDmg, invalid direction under isMove
        cycle(ins(6, 0), 1'b0, 1'b1, 1'b0, 1'b0);
        check("shp_hp", hp, 95);
        check("shp_ack", dmgAck, 1);
        cycle(ins(5, 7), 1'b1, 1'b0, 1'b0, 1'b0);
        check("bad_dir_posX", posX, 320);
        check("bad_dir_posY", posY, 240);
        check("bad_dir_ack", dmgAck, 0);

        // Invulnerability window boundary: edge N+INVULN ignored, N+INVULN+1 applied
        cycle(ins(0, 0), 1'b0, 1'b0, 1'b1, 1'b0);
        cycle(ins(2, 10), 1'b0, 1'b1, 1'b0, 1'b0);
        check("hit_start_hp", hp, 90);
        repeat (INVULN - 1) idle();
        cycle(ins(2, 10), 1'b0, 1'b1, 1'b0, 1'b0);
        check("hit_last_cycle_hp", hp, 90);
        cycle(ins(2, 10), 1'b0, 1'b1, 1'b0, 1'b0);
        check("hit_expired_hp", hp, 80);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r, pick, op, opd;
            logic sd, mv, rs, rst;
            r    = int'($urandom_range(0, 199));
            rst  = (r == 0);
            rs   = (r >= 1 && r <= 3);
            sd   = ($urandom_range(0, 2) == 0);
            mv   = ($urandom_range(0, 1) == 1);
            pick = int'($urandom_range(0, 9));
            case (pick)
                0, 1:    op = 1;
                2, 3:    op = 2;
                4, 5, 6: op = 5;
                default: op = int'($urandom_range(0, 15));
            endcase
            opd = (op == 5) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 40));
            cycle(ins(op, opd), mv, sd, rs, rst);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
